// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch unit: fetch-queue payload, FSM states.
package fetch_pkg;

  localparam int unsigned FETCH_XLEN  = 32;
  localparam int unsigned INSTR_W     = 32;
  localparam int unsigned INSTR_BYTES = 4;

  typedef logic [INSTR_W-1:0] t_rv_instr;

  typedef struct packed {
    logic [FETCH_XLEN-1:0] pc;
    t_rv_instr             instr;
  } t_fq_entry;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } t_fetch_state;

endpackage

// File: rtl/fetch_queue.sv
// Generic circular FIFO with registered storage; clear beats push and pop.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter type         T     = t_fq_entry
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear,
  input  logic                       push,
  input  T                           push_data,
  input  logic                       pop,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output T                           head
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  T              mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (clear) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is reset so the head reads as zero straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[PW'(i)] <= '0;
    end else if (push && !clear) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_ctl.sv
// Instruction fetch: PC generation, credit-limited imem requests, in-order
// response queueing and redirect flush of queued and in-flight instructions.
module fetch_ctl
  import fetch_pkg::*;
#(
  parameter int unsigned     XLEN            = FETCH_XLEN,
  parameter logic [XLEN-1:0] RESET_PC        = '0,
  parameter int unsigned     FQ_DEPTH        = 4,
  parameter int unsigned     MAX_OUTSTANDING = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            fetch_en,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            valid_de0,
  output t_rv_instr       instr_de0,
  output logic [XLEN-1:0] pc_de0,
  input  logic            stall_de1
);

  localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned QW = $clog2(FQ_DEPTH + 1);

  t_fetch_state    state_q, state_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;
  logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
  logic [OW-1:0]   outstanding_q, outstanding_d;
  logic [OW-1:0]   drop_cnt_q, drop_cnt_d;

  logic [QW-1:0]   fq_count;
  t_fq_entry       fq_head;
  t_fq_entry       fq_wdata;
  logic            fq_push;
  logic            fq_pop;
  logic            active;
  logic            slot_ok;
  logic            credit_ok;
  logic            req_fire;
  logic [XLEN-1:0] redirect_aligned;

  assign active           = (state_q == RUN) || (state_q == FLUSH);
  assign slot_ok          = 32'(outstanding_q) < MAX_OUTSTANDING;
  // Queue slots are reserved at issue, so a response always has room.
  assign credit_ok        = (32'(fq_count) + 32'(outstanding_q)) < FQ_DEPTH;
  assign imem_req_valid   = active && fetch_en && !redirect_valid && slot_ok && credit_ok;
  assign imem_req_addr    = req_pc_q;
  assign req_fire         = imem_req_valid && imem_req_ready;
  assign redirect_aligned = redirect_pc & ~XLEN'(3);

  always_comb begin
    state_d       = state_q;
    req_pc_d      = req_pc_q;
    rsp_pc_d      = rsp_pc_q;
    drop_cnt_d    = drop_cnt_q;
    fq_push       = 1'b0;
    outstanding_d = outstanding_q + OW'(req_fire) - OW'(imem_rsp_valid);

    if (req_fire) req_pc_d = req_pc_q + XLEN'(INSTR_BYTES);

    // Redirect wins: everything still in flight after this cycle is stale.
    if (redirect_valid) begin
      req_pc_d   = redirect_aligned;
      rsp_pc_d   = redirect_aligned;
      drop_cnt_d = outstanding_d;
    end else if (imem_rsp_valid) begin
      if (drop_cnt_q != '0) begin
        drop_cnt_d = drop_cnt_q - OW'(1);
      end else begin
        fq_push  = 1'b1;
        rsp_pc_d = rsp_pc_q + XLEN'(INSTR_BYTES);
      end
    end

    case (state_q)
      IDLE:       state_d = RUN;
      RUN, FLUSH: state_d = (drop_cnt_d != '0) ? FLUSH : RUN;
      default:    state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      req_pc_q      <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      req_pc_q      <= req_pc_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  always_comb begin
    fq_wdata       = '0;
    fq_wdata.pc    = FETCH_XLEN'(rsp_pc_q);
    fq_wdata.instr = imem_rsp_data;
  end

  assign fq_pop = valid_de0 && !stall_de1;

  fetch_queue #(
    .DEPTH (FQ_DEPTH),
    .T     (t_fq_entry)
  ) u_fq (
    .clk       (clk),
    .rst_n     (reset),
    .clear     (redirect_valid),
    .push      (fq_push),
    .push_data (fq_wdata),
    .pop       (fq_pop),
    .count     (fq_count),
    .head      (fq_head)
  );

  assign valid_de0 = (fq_count != '0);
  assign instr_de0 = fq_head.instr;
  assign pc_de0    = XLEN'(fq_head.pc);

endmodule

// File: tb/tb_fetch_ctl.sv
// Directed bench for fetch_ctl with an in-order variable-latency imem model.
module tb_fetch_ctl;
  import fetch_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic        clk;
  logic        reset;
  logic        fetch_en;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        valid_de0;
  logic [31:0] instr_de0;
  logic [31:0] pc_de0;
  logic        stall_de1;

  int          n_assert;
  int          n_fail;
  int          cyc;
  int          lat;
  int          n_deliv;
  int          n_req;
  logic [31:0] exp_pc;
  logic [31:0] exp_req;
  logic        rand_rdy;
  logic        inv_on;
  logic [31:0] mq_addr[$];
  int          mq_due[$];
  logic [31:0] acc_log[$];

  fetch_ctl #(
    .XLEN            (32),
    .RESET_PC        (RST_PC),
    .FQ_DEPTH        (4),
    .MAX_OUTSTANDING (2)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .fetch_en       (fetch_en),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .valid_de0      (valid_de0),
    .instr_de0      (instr_de0),
    .pc_de0         (pc_de0),
    .stall_de1      (stall_de1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: observed no finish, required finish before 500us");
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: score the cycle's handshakes, advance, then drive memory responses.
  task automatic tick();
    logic        acc;
    logic [31:0] aaddr;
    logic        rsp_now;
    #1;
    acc     = imem_req_valid && imem_req_ready;
    aaddr   = imem_req_addr;
    rsp_now = imem_rsp_valid;
    if (valid_de0 && !stall_de1) begin
      check("de0_pc", pc_de0, exp_pc);
      check("de0_instr", instr_de0, memf(exp_pc));
      exp_pc = exp_pc + 32'd4;
      n_deliv++;
    end
    if (acc) begin
      check("req_addr", aaddr, exp_req);
      exp_req = exp_req + 32'd4;
      n_req++;
      acc_log.push_back(aaddr);
    end
    if (redirect_valid) begin
      check("no_req_on_redirect", imem_req_valid, 0);
      exp_pc  = redirect_pc & ~32'h3;
      exp_req = redirect_pc & ~32'h3;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (rsp_now) begin
      mq_addr.delete(0);
      mq_due.delete(0);
    end
    if (acc) begin
      mq_addr.push_back(aaddr);
      mq_due.push_back(cyc - 1 + lat);
    end
    if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = memf(mq_addr[0]);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
    if (rand_rdy) imem_req_ready = 1'($urandom_range(0, 1));
    if (inv_on) begin
      check("max_outstanding", 64'(mq_addr.size() <= 2), 64'd1);
      check("credit_bound", 64'((32'(dut.fq_count) + 32'(dut.outstanding_q)) <= 32'd4), 64'd1);
    end
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    reset   = 1'b1;
    cyc     = 0;
    n_deliv = 0;
    n_req   = 0;
    exp_pc  = RST_PC;
    exp_req = RST_PC;
  endtask

  task automatic do_reset();
    reset          = 1'b0;
    fetch_en       = 1'b1;
    stall_de1      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    mq_addr.delete();
    mq_due.delete();
    #1;
    check("rst_req_valid", imem_req_valid, 0);
    check("rst_req_addr", imem_req_addr, RST_PC);
    check("rst_valid_de0", valid_de0, 0);
    check("rst_instr_de0", instr_de0, 0);
    check("rst_pc_de0", pc_de0, 0);
    release_reset();
    check("idle_no_req", imem_req_valid, 0);
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rand_rdy = 1'b0;
    inv_on   = 1'b0;
    lat      = 1;
    reset    = 1'b1;
    #2;

    // 1: startup latency and streaming
    do_reset();
    tick();
    check("t1_c1_req_valid", imem_req_valid, 1);
    check("t1_c1_req_addr", imem_req_addr, 32'h100);
    check("t1_c1_valid", valid_de0, 0);
    tick();
    check("t1_c2_valid", valid_de0, 0);
    check("t1_c2_req_addr", imem_req_addr, 32'h104);
    tick();
    check("t1_c3_valid", valid_de0, 1);
    check("t1_c3_pc", pc_de0, 32'h100);
    check("t1_c3_instr", instr_de0, 32'h0100_FEFF);
    for (int i = 0; i < 6; i++) begin
      tick();
      check("t1_stream_valid", valid_de0, 1);
    end

    // 2: stall fills the queue, then drains in order
    do_reset();
    stall_de1 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (cyc >= 3) begin
        check("t2_hold_valid", valid_de0, 1);
        check("t2_hold_pc", pc_de0, 32'h100);
      end
    end
    check("t2_fq_count", dut.fq_count, 4);
    check("t2_req_blocked", imem_req_valid, 0);
    check("t2_n_req", n_req, 4);
    check("t2_hold_instr", instr_de0, 32'h0100_FEFF);
    stall_de1 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("t2_drain_valid", valid_de0, 1);
    end
    check("t2_n_deliv", n_deliv, 8);

    // 3: redirect with two requests in flight, latency 3
    lat = 3;
    do_reset();
    tick();
    tick();
    tick();
    check("t3_full_no_req", imem_req_valid, 0);
    check("t3_outstanding", dut.outstanding_q, 2);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h2003;
    tick();
    redirect_valid = 1'b0;
    check("t3_flush_state", dut.state_q, FLUSH);
    check("t3_drop_cnt", dut.drop_cnt_q, 2);
    check("t3_valid_after_redirect", valid_de0, 0);
    for (int i = 0; i < 30; i++) begin
      if (valid_de0) break;
      tick();
    end
    check("t3_valid", valid_de0, 1);
    check("t3_pc", pc_de0, 32'h2000);
    check("t3_instr", instr_de0, 32'h2000_DFFF);
    check("t3_back_to_run", dut.state_q, RUN);
    for (int i = 0; i < 6; i++) tick();

    // 4: redirect coinciding with a response and a dequeue
    lat = 1;
    do_reset();
    for (int i = 0; i < 6; i++) tick();
    check("t4_pre_valid", valid_de0, 1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h3000;
    #1;
    check("t4_no_req", imem_req_valid, 0);
    tick();
    redirect_valid = 1'b0;
    #1;
    check("t4_empty", valid_de0, 0);
    check("t4_fq_count", dut.fq_count, 0);
    check("t4_req_valid", imem_req_valid, 1);
    check("t4_req_addr", imem_req_addr, 32'h3000);
    check("t4_state", dut.state_q, RUN);
    for (int i = 0; i < 5; i++) tick();
    check("t4_resume_valid", valid_de0, 1);

    // 5: random ready and stall, fetch_en pulsed off
    lat = 2;
    do_reset();
    rand_rdy = 1'b1;
    inv_on   = 1'b1;
    for (int i = 0; i < 80; i++) begin
      stall_de1 = ($urandom_range(0, 3) == 0);
      fetch_en  = !(i >= 30 && i < 35);
      if (!fetch_en) begin
        #1;
        check("t5_fetch_off", imem_req_valid, 0);
      end
      tick();
    end
    fetch_en       = 1'b1;
    stall_de1      = 1'b0;
    rand_rdy       = 1'b0;
    imem_req_ready = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    inv_on = 1'b0;
    check("t5_progress", 64'(n_deliv > 20), 64'd1);

    // 6: address wrap, then asynchronous reset mid-stream
    lat = 1;
    do_reset();
    for (int i = 0; i < 4; i++) tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFF8;
    tick();
    redirect_valid = 1'b0;
    acc_log.delete();
    for (int i = 0; i < 6; i++) tick();
    check("t6_acc_count", 64'(acc_log.size() >= 3), 64'd1);
    check("t6_wrap0", acc_log[0], 32'hFFFF_FFF8);
    check("t6_wrap1", acc_log[1], 32'hFFFF_FFFC);
    check("t6_wrap2", acc_log[2], 32'h0000_0000);
    #2;
    reset = 1'b0;
    #1;
    check("t6_rst_req_valid", imem_req_valid, 0);
    check("t6_rst_req_addr", imem_req_addr, RST_PC);
    check("t6_rst_valid", valid_de0, 0);
    check("t6_rst_pc", pc_de0, 0);
    check("t6_rst_instr", instr_de0, 0);
    check("t6_rst_state", dut.state_q, IDLE);
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    mq_addr.delete();
    mq_due.delete();
    release_reset();
    tick();
    check("t6_restart_valid", imem_req_valid, 1);
    check("t6_restart_addr", imem_req_addr, RST_PC);
    for (int i = 0; i < 5; i++) tick();
    check("t6_restart_deliv", valid_de0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
